// File: rtl/axis_flit_packetizer_if.sv
// Bundle of the AXI-Stream beat input, the router flit/credit port and the
// debug taps of axis_flit_packetizer; widths derive from the same parameters as the block.
interface axis_flit_packetizer_if #(
    parameter int TDATA_WIDTH          = 128,
    parameter int DEST_WIDTH           = 4,
    parameter int SERIALIZATION_FACTOR = 2,
    parameter int FLIT_BUFFER_DEPTH    = 1,
    parameter int BUFFER_DEPTH         = 2
);
    localparam int FLIT_WIDTH = TDATA_WIDTH / SERIALIZATION_FACTOR;
    localparam int CREDIT_W   = $clog2(FLIT_BUFFER_DEPTH + 1);
    localparam int OCC_W      = $clog2(BUFFER_DEPTH + 1);
    localparam int IDX_W      = (SERIALIZATION_FACTOR > 1) ? $clog2(SERIALIZATION_FACTOR) : 1;

    // axis_*: a beat transfers on a rising edge where tvalid and tready are both
    // high; tready never depends on tvalid. Flit side: one flit per cycle with
    // send_out=1, no back-pressure; each credit_in cycle returns one buffer slot.
    logic                   axis_tvalid;
    logic                   axis_tready;
    logic [TDATA_WIDTH-1:0] axis_tdata;
    logic                   axis_tlast;
    logic [DEST_WIDTH-1:0]  axis_tdest;

    logic [FLIT_WIDTH-1:0]  data_out;
    logic [DEST_WIDTH-1:0]  dest_out;
    logic                   is_tail_out;
    logic                   send_out;
    logic                   credit_in;

    logic [CREDIT_W-1:0]    dbg_credits;
    logic [OCC_W-1:0]       dbg_occupancy;
    logic [IDX_W-1:0]       dbg_flit_idx;

    modport slave (
        input  axis_tvalid, axis_tdata, axis_tlast, axis_tdest, credit_in,
        output axis_tready, data_out, dest_out, is_tail_out, send_out,
        output dbg_credits, dbg_occupancy, dbg_flit_idx
    );

    modport master (
        output axis_tvalid, axis_tdata, axis_tlast, axis_tdest, credit_in,
        input  axis_tready, data_out, dest_out, is_tail_out, send_out,
        input  dbg_credits, dbg_occupancy, dbg_flit_idx
    );
endinterface

// File: rtl/axis_flit_packetizer.sv
// Same-clock injection stage: buffers AXI-Stream beats and serializes each one
// into SERIALIZATION_FACTOR flits for router port 0 under credit flow control.
module axis_flit_packetizer #(
    parameter int TDATA_WIDTH          = 128,
    parameter int DEST_WIDTH           = 4,
    parameter int SERIALIZATION_FACTOR = 2,
    parameter int FLIT_BUFFER_DEPTH    = 1,
    parameter int BUFFER_DEPTH         = 2
) (
    input logic             clk_noc,
    input logic             rst_n,
    axis_flit_packetizer_if.slave bus
);
    localparam int FLIT_WIDTH = TDATA_WIDTH / SERIALIZATION_FACTOR;
    localparam int PTR_W      = (BUFFER_DEPTH > 1) ? $clog2(BUFFER_DEPTH) : 1;
    localparam int OCC_W      = $clog2(BUFFER_DEPTH + 1);
    localparam int CREDIT_W   = $clog2(FLIT_BUFFER_DEPTH + 1);
    localparam int IDX_W      = (SERIALIZATION_FACTOR > 1) ? $clog2(SERIALIZATION_FACTOR) : 1;

    localparam logic [PTR_W-1:0]    PTR_LAST   = PTR_W'(BUFFER_DEPTH - 1);
    localparam logic [OCC_W-1:0]    OCC_FULL   = OCC_W'(BUFFER_DEPTH);
    localparam logic [CREDIT_W-1:0] CREDIT_MAX = CREDIT_W'(FLIT_BUFFER_DEPTH);
    localparam logic [IDX_W-1:0]    IDX_LAST   = IDX_W'(SERIALIZATION_FACTOR - 1);

    if (SERIALIZATION_FACTOR < 1 || (TDATA_WIDTH % SERIALIZATION_FACTOR) != 0) begin : g_bad_sf
        $error("SERIALIZATION_FACTOR must be >= 1 and divide TDATA_WIDTH");
    end
    if (BUFFER_DEPTH < 1 || FLIT_BUFFER_DEPTH < 1) begin : g_bad_depth
        $error("BUFFER_DEPTH and FLIT_BUFFER_DEPTH must be >= 1");
    end

    typedef struct packed {
        logic [TDATA_WIDTH-1:0] tdata;
        logic                   tlast;
        logic [DEST_WIDTH-1:0]  tdest;
    } entry_t;

    entry_t                mem [BUFFER_DEPTH];
    logic [PTR_W-1:0]      wr_ptr, wr_ptr_nxt;
    logic [PTR_W-1:0]      rd_ptr, rd_ptr_nxt;
    logic [OCC_W-1:0]      occ, occ_nxt;
    logic [CREDIT_W-1:0]   credits, credits_nxt;
    logic [IDX_W-1:0]      idx, idx_nxt;

    logic                  send_q;
    logic                  tail_q;
    logic [FLIT_WIDTH-1:0] data_q;
    logic [DEST_WIDTH-1:0] dest_q;

    logic                  can_accept;
    logic                  push;
    logic                  pop;
    logic                  issue;
    logic                  last_flit;
    entry_t                head;
    logic [FLIT_WIDTH-1:0] head_flit;

    // Acceptance looks only at the registered occupancy, so a full FIFO never
    // takes a beat in the same cycle it pops one.
    assign can_accept = (occ < OCC_FULL);
    assign push       = bus.axis_tvalid & can_accept;
    assign issue      = (occ != '0) && (credits != '0);
    assign last_flit  = (idx == IDX_LAST);
    assign pop        = issue & last_flit;
    assign head       = mem[rd_ptr];

    always_comb begin
        head_flit = head.tdata[FLIT_WIDTH-1:0];
        for (int i = 0; i < SERIALIZATION_FACTOR; i++) begin
            if (idx == IDX_W'(i)) begin
                head_flit = head.tdata[i*FLIT_WIDTH +: FLIT_WIDTH];
            end
        end
    end

    always_comb begin
        wr_ptr_nxt  = wr_ptr;
        rd_ptr_nxt  = rd_ptr;
        occ_nxt     = occ;
        credits_nxt = credits;
        idx_nxt     = idx;

        if (push) begin
            wr_ptr_nxt = (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
        end
        if (pop) begin
            rd_ptr_nxt = (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
        end

        unique case ({push, pop})
            2'b10:   occ_nxt = occ + 1'b1;
            2'b01:   occ_nxt = occ - 1'b1;
            default: occ_nxt = occ;
        endcase

        // A credit arriving while a flit issues cancels out; an extra credit
        // at the maximum is a protocol error and is dropped.
        unique case ({issue, bus.credit_in})
            2'b10:   credits_nxt = credits - 1'b1;
            2'b01:   credits_nxt = (credits == CREDIT_MAX) ? credits : credits + 1'b1;
            default: credits_nxt = credits;
        endcase

        if (issue) begin
            idx_nxt = last_flit ? '0 : idx + 1'b1;
        end
    end

    always_ff @(posedge clk_noc) begin
        if (rst_n && push) begin
            mem[wr_ptr] <= '{tdata: bus.axis_tdata, tlast: bus.axis_tlast, tdest: bus.axis_tdest};
        end
    end

    always_ff @(posedge clk_noc) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            occ     <= '0;
            credits <= CREDIT_MAX;
            idx     <= '0;
            send_q  <= 1'b0;
            tail_q  <= 1'b0;
            data_q  <= '0;
            dest_q  <= '0;
        end else begin
            wr_ptr  <= wr_ptr_nxt;
            rd_ptr  <= rd_ptr_nxt;
            occ     <= occ_nxt;
            credits <= credits_nxt;
            idx     <= idx_nxt;
            send_q  <= issue;
            if (issue) begin
                data_q <= head_flit;
                dest_q <= head.tdest;
                tail_q <= head.tlast & last_flit;
            end
        end
    end

    assign bus.axis_tready   = can_accept & rst_n;
    assign bus.send_out      = send_q;
    assign bus.data_out      = data_q;
    assign bus.dest_out      = dest_q;
    assign bus.is_tail_out   = tail_q;
    assign bus.dbg_credits   = credits;
    assign bus.dbg_occupancy = occ;
    assign bus.dbg_flit_idx  = idx;

    credit_overflow: assert property (@(posedge clk_noc) disable iff (!rst_n)
        !(bus.credit_in && !issue && credits == CREDIT_MAX));

    occupancy_in_range: assert property (@(posedge clk_noc) disable iff (!rst_n)
        occ <= OCC_FULL);
endmodule

// File: tb/tb_axis_flit_packetizer.sv
// Bench for axis_flit_packetizer: a 128-bit/SF=2/FBD=4 instance and a
// 32-bit/SF=1/FBD=1 instance, each with its own flit scoreboard queue.
module tb_axis_flit_packetizer;
    localparam int M_TW = 128, M_DW = 4, M_SF = 2, M_FBD = 4, M_BD = 2, M_FW = 64;
    localparam int S_TW = 32,  S_DW = 4, S_SF = 1, S_FBD = 1, S_BD = 2, S_FW = 32;
    localparam int M_EW = M_FW + M_DW + 1;
    localparam int S_EW = S_FW + S_DW + 1;

    logic clk_noc = 1'b0;
    logic rst_n   = 1'b0;
    int   cyc     = 0;

    always #5 clk_noc = ~clk_noc;
    always @(posedge clk_noc) cyc <= cyc + 1;

    axis_flit_packetizer_if #(.TDATA_WIDTH(M_TW), .DEST_WIDTH(M_DW), .SERIALIZATION_FACTOR(M_SF),
        .FLIT_BUFFER_DEPTH(M_FBD), .BUFFER_DEPTH(M_BD)) m_if ();
    axis_flit_packetizer_if #(.TDATA_WIDTH(S_TW), .DEST_WIDTH(S_DW), .SERIALIZATION_FACTOR(S_SF),
        .FLIT_BUFFER_DEPTH(S_FBD), .BUFFER_DEPTH(S_BD)) s_if ();

    axis_flit_packetizer #(.TDATA_WIDTH(M_TW), .DEST_WIDTH(M_DW), .SERIALIZATION_FACTOR(M_SF),
        .FLIT_BUFFER_DEPTH(M_FBD), .BUFFER_DEPTH(M_BD)) u_m (
        .clk_noc(clk_noc), .rst_n(rst_n), .bus(m_if.slave));
    axis_flit_packetizer #(.TDATA_WIDTH(S_TW), .DEST_WIDTH(S_DW), .SERIALIZATION_FACTOR(S_SF),
        .FLIT_BUFFER_DEPTH(S_FBD), .BUFFER_DEPTH(S_BD)) u_s (
        .clk_noc(clk_noc), .rst_n(rst_n), .bus(s_if.slave));

    int n_cmp  = 0;
    int n_fail = 0;

    logic [M_EW-1:0] m_q[$];
    logic [S_EW-1:0] s_q[$];
    logic [M_EW-1:0] m_exp;
    logic [S_EW-1:0] s_exp;
    int m_send_cnt = 0, m_first = 0, m_last = 0;
    int s_send_cnt = 0, s_first = 0, s_last = 0;
    logic m_auto = 1'b0, s_auto = 1'b0;

    typedef struct {
        logic [M_TW-1:0] tdata;
        logic            tlast;
        logic [M_DW-1:0] tdest;
        logic [M_FW-1:0] exp_lo;
        logic [M_FW-1:0] exp_hi;
        logic            exp_tail;
    } vec_t;
    vec_t tbl [6];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Flit scoreboards: every send_out cycle pops one expected flit.
    always @(negedge clk_noc) begin
        if (m_if.send_out === 1'b1) begin
            if (m_send_cnt == 0) m_first = cyc;
            m_last = cyc;
            m_send_cnt++;
            if (m_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL m_flit_unexpected: got %0h, expected no flit", m_if.data_out);
            end else begin
                m_exp = m_q.pop_front();
                check("m_flit", {m_if.data_out, m_if.dest_out, m_if.is_tail_out}, m_exp);
            end
        end
        if (s_if.send_out === 1'b1) begin
            if (s_send_cnt == 0) s_first = cyc;
            s_last = cyc;
            s_send_cnt++;
            if (s_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL s_flit_unexpected: got %0h, expected no flit", s_if.data_out);
            end else begin
                s_exp = s_q.pop_front();
                check("s_flit", {s_if.data_out, s_if.dest_out, s_if.is_tail_out}, s_exp);
            end
        end
    end

    // Consumer model returning one credit in the cycle a flit is seen.
    always @(posedge clk_noc) begin
        #1;
        if (m_auto) m_if.credit_in = m_if.send_out;
        if (s_auto) s_if.credit_in = s_if.send_out;
    end

    function automatic void m_expect(input logic [M_TW-1:0] d, input logic l, input logic [M_DW-1:0] dst);
        for (int i = 0; i < M_SF; i++) begin
            m_q.push_back({d[i*M_FW +: M_FW], dst, l && (i == M_SF - 1)});
        end
    endfunction

    function automatic void s_expect(input logic [S_TW-1:0] d, input logic l, input logic [S_DW-1:0] dst);
        s_q.push_back({d, dst, l});
    endfunction

    task automatic m_drive(input logic [M_TW-1:0] d, input logic l, input logic [M_DW-1:0] dst, output int waits);
        logic hs;
        logic done;
        waits = 0;
        done  = 1'b0;
        m_if.axis_tvalid = 1'b1;
        m_if.axis_tdata  = d;
        m_if.axis_tlast  = l;
        m_if.axis_tdest  = dst;
        for (int i = 0; i < 50; i++) begin
            hs = m_if.axis_tready;
            @(posedge clk_noc);
            #1;
            if (hs) begin
                done = 1'b1;
                break;
            end
            waits++;
        end
        m_if.axis_tvalid = 1'b0;
        if (!done) begin
            n_cmp++;
            n_fail++;
            $display("FAIL m_drive_timeout: tready %0b for 50 cycles, expected 1", m_if.axis_tready);
        end
    endtask

    task automatic s_drive(input logic [S_TW-1:0] d, input logic l, input logic [S_DW-1:0] dst);
        logic hs;
        logic done;
        done = 1'b0;
        s_if.axis_tvalid = 1'b1;
        s_if.axis_tdata  = d;
        s_if.axis_tlast  = l;
        s_if.axis_tdest  = dst;
        for (int i = 0; i < 50; i++) begin
            hs = s_if.axis_tready;
            @(posedge clk_noc);
            #1;
            if (hs) begin
                done = 1'b1;
                break;
            end
        end
        s_if.axis_tvalid = 1'b0;
        if (!done) begin
            n_cmp++;
            n_fail++;
            $display("FAIL s_drive_timeout: tready %0b for 50 cycles, expected 1", s_if.axis_tready);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_noc);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench exceeded its time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t, w, s, r, z, u;
        int waits [4];
        logic [M_TW-1:0] d;

        for (int i = 0; i < 6; i++) begin
            tbl[i].exp_lo   = {$urandom(), $urandom()};
            tbl[i].exp_hi   = {$urandom(), $urandom()};
            tbl[i].tdata    = {tbl[i].exp_hi, tbl[i].exp_lo};
            tbl[i].tlast    = (i == 1) || (i == 2) || (i == 5);
            tbl[i].tdest    = 4'(i * 3 + 1);
            tbl[i].exp_tail = tbl[i].tlast;
        end

        m_if.axis_tvalid = 1'b0; m_if.axis_tdata = '0; m_if.axis_tlast = 1'b0;
        m_if.axis_tdest = '0; m_if.credit_in = 1'b0;
        s_if.axis_tvalid = 1'b0; s_if.axis_tdata = '0; s_if.axis_tlast = 1'b0;
        s_if.axis_tdest = '0; s_if.credit_in = 1'b0;

        rst_n = 1'b0;
        tick(3);
        check("rst_send",   m_if.send_out, 0);
        check("rst_data",   m_if.data_out, 0);
        check("rst_dest",   m_if.dest_out, 0);
        check("rst_tail",   m_if.is_tail_out, 0);
        check("rst_tready", m_if.axis_tready, 0);
        check("rst_s_tready", s_if.axis_tready, 0);
        check("rst_credits", m_if.dbg_credits, M_FBD);
        rst_n = 1'b1;
        #1;
        check("rel_tready",  m_if.axis_tready, 1);
        check("rel_s_tready", s_if.axis_tready, 1);
        check("rel_occ",     m_if.dbg_occupancy, 0);
        tick(1);

        // Single two-flit tail beat: latency and slice order.
        t = cyc;
        m_drive({64'hAAAA_AAAA_AAAA_AAAA, 64'hBBBB_BBBB_BBBB_BBBB}, 1'b1, 4'h5, w);
        m_expect({64'hAAAA_AAAA_AAAA_AAAA, 64'hBBBB_BBBB_BBBB_BBBB}, 1'b1, 4'h5);
        check("a_hs_wait", w, 0);
        check("a_send_t1", m_if.send_out, 0);
        tick(1);
        check("a_send_t2", m_if.send_out, 1);
        check("a_data_t2", m_if.data_out, 64'hBBBB_BBBB_BBBB_BBBB);
        check("a_tail_t2", m_if.is_tail_out, 0);
        check("a_dest_t2", m_if.dest_out, 5);
        tick(1);
        check("a_send_t3", m_if.send_out, 1);
        check("a_data_t3", m_if.data_out, 64'hAAAA_AAAA_AAAA_AAAA);
        check("a_tail_t3", m_if.is_tail_out, 1);
        check("a_credits_t3", m_if.dbg_credits, 2);
        tick(1);
        check("a_send_t4", m_if.send_out, 0);
        m_if.credit_in = 1'b1;
        tick(2);
        m_if.credit_in = 1'b0;
        tick(1);
        check("a_credits_back", m_if.dbg_credits, M_FBD);

        // Table-driven beats with the consumer returning credits.
        m_auto = 1'b1;
        for (int i = 0; i < 6; i++) begin
            m_drive(tbl[i].tdata, tbl[i].tlast, tbl[i].tdest, w);
            m_q.push_back({tbl[i].exp_lo, tbl[i].tdest, 1'b0});
            m_q.push_back({tbl[i].exp_hi, tbl[i].tdest, tbl[i].exp_tail});
        end
        tick(12);
        m_auto = 1'b0;
        m_if.credit_in = 1'b0;
        check("tbl_drained", m_q.size(), 0);
        check("tbl_credits", m_if.dbg_credits, M_FBD);

        // Four back-to-back single-beat packets: eight consecutive flits.
        m_auto = 1'b1;
        m_send_cnt = 0;
        t = cyc;
        for (int i = 0; i < 4; i++) begin
            d = {$urandom(), $urandom(), $urandom(), $urandom()};
            m_drive(d, 1'b1, 4'(i + 8), waits[i]);
            m_expect(d, 1'b1, 4'(i + 8));
        end
        check("str_wait0", waits[0], 0);
        check("str_wait1", waits[1], 0);
        check("str_wait2", waits[2], 1);
        check("str_wait3", waits[3], 1);
        tick(8);
        m_auto = 1'b0;
        m_if.credit_in = 1'b0;
        check("str_sends", m_send_cnt, 8);
        check("str_first", m_first, t + 2);
        check("str_last",  m_last,  t + 9);
        check("str_drained", m_q.size(), 0);
        check("str_credits", m_if.dbg_credits, M_FBD);

        // Credit return coinciding with an issue while the counter is 1.
        m_send_cnt = 0;
        s = cyc;
        fork
            begin
                for (int i = 0; i < 3; i++) begin
                    d = {$urandom(), $urandom(), $urandom(), $urandom()};
                    m_drive(d, (i == 2), 4'h3, w);
                    m_expect(d, (i == 2), 4'h3);
                end
            end
            begin
                tick(4);
                check("c_credits_s4", m_if.dbg_credits, 1);
                m_if.credit_in = 1'b1;
                for (int j = 5; j <= 7; j++) begin
                    tick(1);
                    check("c_credits_held", m_if.dbg_credits, 1);
                    check("c_send_held", m_if.send_out, 1);
                end
                tick(3);
                m_if.credit_in = 1'b0;
                check("c_credits_back", m_if.dbg_credits, M_FBD);
            end
        join
        check("c_sends", m_send_cnt, 6);
        check("c_first", m_first, s + 2);
        check("c_last",  m_last,  s + 7);

        // Reset after flit 0 of a beat with another beat queued.
        r = cyc;
        d = {64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888};
        m_drive(d, 1'b1, 4'h9, w);
        m_expect(d, 1'b1, 4'h9);
        m_drive(~d, 1'b1, 4'hA, w);
        m_expect(~d, 1'b1, 4'hA);
        check("r_flit0_send", m_if.send_out, 1);
        check("r_flit0_cycle", cyc, r + 2);
        rst_n = 1'b0;
        tick(1);
        m_q.delete();
        for (int i = 0; i < 2; i++) begin
            check("r_send",   m_if.send_out, 0);
            check("r_data",   m_if.data_out, 0);
            check("r_dest",   m_if.dest_out, 0);
            check("r_tail",   m_if.is_tail_out, 0);
            check("r_tready", m_if.axis_tready, 0);
            tick(1);
        end
        rst_n = 1'b1;
        #1;
        check("r_rel_tready",  m_if.axis_tready, 1);
        check("r_rel_credits", m_if.dbg_credits, M_FBD);
        check("r_rel_occ",     m_if.dbg_occupancy, 0);
        check("r_rel_idx",     m_if.dbg_flit_idx, 0);
        tick(1);
        m_send_cnt = 0;
        z = cyc;
        d = {64'hDEAD_BEEF_0000_0001, 64'hCAFE_F00D_0000_0002};
        m_drive(d, 1'b1, 4'h6, w);
        m_expect(d, 1'b1, 4'h6);
        tick(4);
        check("r_new_sends", m_send_cnt, 2);
        check("r_new_first", m_first, z + 2);
        check("r_credits_used", m_if.dbg_credits, M_FBD - 2);
        m_if.credit_in = 1'b1;
        tick(2);
        m_if.credit_in = 1'b0;

        // Single-credit instance: one flit, then resume two cycles after a credit.
        s_send_cnt = 0;
        s_drive(32'h0BAD_0001, 1'b0, 4'h2);
        s_expect(32'h0BAD_0001, 1'b0, 4'h2);
        s_drive(32'h0BAD_0002, 1'b1, 4'h2);
        s_expect(32'h0BAD_0002, 1'b1, 4'h2);
        tick(6);
        check("f1_one_pulse", s_send_cnt, 1);
        u = cyc;
        s_if.credit_in = 1'b1;
        tick(1);
        s_if.credit_in = 1'b0;
        check("f1_not_early", s_if.send_out, 0);
        tick(1);
        check("f1_resume", s_if.send_out, 1);
        check("f1_resume_cycle", cyc, u + 2);
        s_if.credit_in = 1'b1;
        tick(1);
        s_if.credit_in = 1'b0;
        check("f1_credits", s_if.dbg_credits, S_FBD);

        // SF=1 three-beat packet with tail on the last beat.
        s_auto = 1'b1;
        s_send_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            d[31:0] = $urandom();
            s_drive(d[31:0], (i == 2), 4'(i + 4));
            s_expect(d[31:0], (i == 2), 4'(i + 4));
        end
        tick(10);
        s_auto = 1'b0;
        s_if.credit_in = 1'b0;
        check("sf1_sends", s_send_cnt, 3);
        check("sf1_credits", s_if.dbg_credits, S_FBD);

        check("end_m_queue", m_q.size(), 0);
        check("end_s_queue", s_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
